// File: rtl/id_exe_hazard_ctrl.sv
// Hazard controller for the ID/EX boundary: load-use stall, taken-branch flush
// window and memory-not-ready freeze, with saturating debug counters.
module id_exe_hazard_ctrl #(
  parameter int CNT_W        = 16,
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic [CNT_W-1:0] load_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout,
  output logic             fsm_state
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  localparam int TO_BITS = $clog2(MEM_TIMEOUT + 1);
  localparam int WAIT_W  = (TO_BITS > 8) ? TO_BITS : 8;

  state_t            state;
  logic [1:0]        flush_left;
  logic [WAIT_W-1:0] wait_cnt;
  logic              freeze;
  logic              load_use;
  logic              branch_run;

  // The MEM access is a valid/ready pair: mem_req is valid, dmem_ready is
  // ready, and the access completes only in a cycle where both are high.
  assign freeze     = mem_req & ~dmem_ready;
  assign branch_run = (state == RUN) & ex_branch_taken;
  assign load_use   = ex_mem_read & (ex_rd != 5'd0) &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                       (id_uses_rs2 & (id_rs2 == ex_rd)));
  assign fsm_state  = state;

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    if (rst) begin
      pc_write = 1'b1;
    end else if (freeze) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
    end else if (branch_run || state == FLUSH) begin
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      flush_left     <= 2'd0;
      wait_cnt       <= '0;
      load_stall_cnt <= '0;
      flush_cnt      <= '0;
      mem_timeout    <= 1'b0;
    end else if (freeze) begin
      // Saturate so a very long stall cannot wrap and hide the timeout.
      if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
      if (int'(wait_cnt) + 1 >= MEM_TIMEOUT) mem_timeout <= 1'b1;
    end else begin
      wait_cnt <= '0;
      if (branch_run) begin
        if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state      <= FLUSH;
          flush_left <= 2'(FLUSH_CYCLES - 1);
        end
      end else if (state == FLUSH) begin
        if (flush_left == 2'd1) begin
          state      <= RUN;
          flush_left <= 2'd0;
        end else begin
          flush_left <= flush_left - 2'd1;
        end
      end else if (load_use) begin
        if (load_stall_cnt != '1) load_stall_cnt <= load_stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_id_exe_hazard_ctrl.sv
// Bench for id_exe_hazard_ctrl with CNT_W=2, FLUSH_CYCLES=2, MEM_TIMEOUT=4 so
// saturation, the flush window and the timeout are all reachable quickly.
module tb_id_exe_hazard_ctrl;
  localparam int CNT_W = 2;
  localparam int FC    = 2;
  localparam int TO    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic ex_mem_read = 1'b0, ex_branch_taken = 1'b0, mem_req = 1'b0, dmem_ready = 1'b1;
  logic pc_write, if_id_write, id_ex_write, ex_mem_write, id_ex_bubble, if_id_flush;
  logic [CNT_W-1:0] load_stall_cnt, flush_cnt;
  logic mem_timeout, fsm_state;
  logic [5:0] ctrl;

  always #5 clk = ~clk;

  id_exe_hazard_ctrl #(.CNT_W(CNT_W), .FLUSH_CYCLES(FC), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .dmem_ready(dmem_ready), .pc_write(pc_write),
    .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .ex_mem_write(ex_mem_write), .id_ex_bubble(id_ex_bubble),
    .if_id_flush(if_id_flush), .load_stall_cnt(load_stall_cnt),
    .flush_cnt(flush_cnt), .mem_timeout(mem_timeout), .fsm_state(fsm_state)
  );

  // {pc_write, if_id_write, id_ex_write, ex_mem_write, id_ex_bubble, if_id_flush}
  assign ctrl = {pc_write, if_id_write, id_ex_write, ex_mem_write, id_ex_bubble, if_id_flush};

  typedef struct packed {
    logic r; logic [4:0] rs1; logic [4:0] rs2; logic u1; logic u2;
    logic [4:0] rd; logic mr; logic br; logic mq; logic rdy;
  } stim_t;

  logic [5:0] exp_q[$];
  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  logic m_flush = 1'b0;
  logic [1:0] m_left = 2'd0;
  int m_wait = 0;
  logic [CNT_W-1:0] m_lcnt = '0, m_fcnt = '0;
  logic m_to = 1'b0;

  function automatic logic m_lu();
    return ex_mem_read && ex_rd != 5'd0 &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
  endfunction

  function automatic logic [5:0] exp_ctrl();
    if (rst) return 6'b111100;
    if (mem_req && !dmem_ready) return 6'b000000;
    if (m_flush || ex_branch_taken) return 6'b111111;
    if (m_lu()) return 6'b001110;
    return 6'b111100;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_flush <= 1'b0; m_left <= 2'd0; m_wait <= 0;
      m_lcnt <= '0; m_fcnt <= '0; m_to <= 1'b0;
    end else if (mem_req && !dmem_ready) begin
      m_wait <= m_wait + 1;
      if (m_wait + 1 >= TO) m_to <= 1'b1;
    end else begin
      m_wait <= 0;
      if (m_flush) begin
        m_left  <= m_left - 2'd1;
        m_flush <= (m_left != 2'd1);
      end else if (ex_branch_taken) begin
        if (m_fcnt != '1) m_fcnt <= m_fcnt + 1'b1;
        m_flush <= (FC > 1);
        m_left  <= 2'(FC - 1);
      end else if (m_lu()) begin
        if (m_lcnt != '1) m_lcnt <= m_lcnt + 1'b1;
      end
    end
  end

  function automatic stim_t mk(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [4:0] rd,
                               input logic mr, input logic br, input logic mq, input logic rdy);
    stim_t s;
    s.r = r; s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2;
    s.rd = rd; s.mr = mr; s.br = br; s.mq = mq; s.rdy = rdy;
    return s;
  endfunction

  // Apply one cycle of inputs mid-period and queue the expected control word.
  task automatic drive(input stim_t s);
    @(negedge clk);
    rst = s.r; id_rs1 = s.rs1; id_rs2 = s.rs2; id_uses_rs1 = s.u1; id_uses_rs2 = s.u2;
    ex_rd = s.rd; ex_mem_read = s.mr; ex_branch_taken = s.br;
    mem_req = s.mq; dmem_ready = s.rdy;
    #1;
    exp_q.push_back(exp_ctrl());
  endtask

  task automatic test_reset();
    stim_t seq[3];
    logic [5:0] e;
    seq[0] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    seq[1] = mk(1, 3, 3, 1, 1, 3, 1, 0, 1, 0);
    seq[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drive(seq[i]);
      e = exp_q.pop_front();
      n_chk++;
      if (ctrl !== e) begin
        n_fail++;
        $display("FAIL reset_ctrl cyc %0d: ctrl=%b expected %b", i, ctrl, e);
      end
    end
    n_chk++;
    if ({load_stall_cnt, flush_cnt, mem_timeout, fsm_state} !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: lcnt=%0d fcnt=%0d to=%b st=%b expected all 0",
               load_stall_cnt, flush_cnt, mem_timeout, fsm_state);
    end
  endtask

  task automatic test_load_use();
    stim_t seq[3];
    logic [5:0] e;
    seq[0] = mk(0, 1, 5, 0, 1, 5, 1, 0, 0, 1);
    seq[1] = mk(0, 1, 5, 0, 1, 5, 0, 0, 1, 1);
    seq[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drive(seq[i]);
      e = exp_q.pop_front();
      n_chk++;
      if (ctrl !== e) begin
        n_fail++;
        $display("FAIL load_use_ctrl cyc %0d: ctrl=%b expected %b", i, ctrl, e);
      end
    end
    n_chk++;
    if (load_stall_cnt !== 2'd1) begin
      n_fail++;
      $display("FAIL load_use_cnt: got %0d expected 1", load_stall_cnt);
    end
  endtask

  task automatic test_x0_unused();
    stim_t seq[3];
    logic [5:0] e;
    seq[0] = mk(0, 0, 9, 1, 0, 0, 1, 0, 0, 1);
    seq[1] = mk(0, 7, 9, 0, 1, 7, 1, 0, 0, 1);
    seq[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drive(seq[i]);
      e = exp_q.pop_front();
      n_chk++;
      if (ctrl !== e || ctrl !== 6'b111100) begin
        n_fail++;
        $display("FAIL x0_unused_ctrl cyc %0d: ctrl=%b expected 111100", i, ctrl);
      end
    end
    n_chk++;
    if (load_stall_cnt !== 2'd1) begin
      n_fail++;
      $display("FAIL x0_unused_cnt: got %0d expected 1", load_stall_cnt);
    end
  endtask

  task automatic test_branch();
    stim_t seq[3];
    logic [5:0] e;
    seq[0] = mk(0, 2, 0, 1, 0, 2, 1, 1, 0, 1);
    seq[1] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    seq[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drive(seq[i]);
      e = exp_q.pop_front();
      n_chk++;
      if (ctrl !== e) begin
        n_fail++;
        $display("FAIL branch_ctrl cyc %0d: ctrl=%b expected %b", i, ctrl, e);
      end
    end
    n_chk++;
    if (flush_cnt !== 2'd1 || load_stall_cnt !== 2'd1) begin
      n_fail++;
      $display("FAIL branch_cnt: fcnt=%0d lcnt=%0d expected 1 and 1", flush_cnt, load_stall_cnt);
    end
  endtask

  task automatic test_freeze();
    stim_t seq[6];
    logic [5:0] e;
    for (int i = 0; i < 3; i++) seq[i] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    seq[3] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    seq[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    seq[5] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      drive(seq[i]);
      e = exp_q.pop_front();
      n_chk++;
      if (ctrl !== e) begin
        n_fail++;
        $display("FAIL freeze_ctrl cyc %0d: ctrl=%b expected %b", i, ctrl, e);
      end
    end
    n_chk++;
    if (flush_cnt !== 2'd2 || mem_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL freeze_regs: fcnt=%0d to=%b expected 2 and 0", flush_cnt, mem_timeout);
    end
  endtask

  task automatic test_timeout();
    stim_t s;
    logic [5:0] e;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) s = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      else if (i == 6) s = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      else s = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      drive(s);
      e = exp_q.pop_front();
      n_chk++;
      if (ctrl !== e) begin
        n_fail++;
        $display("FAIL timeout_ctrl cyc %0d: ctrl=%b expected %b", i, ctrl, e);
      end
      n_chk++;
      if (mem_timeout !== (i >= 4 && i <= 6)) begin
        n_fail++;
        $display("FAIL timeout_flag cyc %0d: got %b expected %b", i, mem_timeout, (i >= 4 && i <= 6));
      end
    end
  endtask

  task automatic test_saturation_reset();
    stim_t seq[13];
    logic [5:0] e;
    for (int i = 0; i < 10; i++)
      seq[i] = (i % 2 == 0) ? mk(0, 3, 0, 1, 0, 3, 1, 0, 0, 1) : mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    seq[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    seq[11] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    seq[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 13; i++) begin
      drive(seq[i]);
      e = exp_q.pop_front();
      n_chk++;
      if (ctrl !== e) begin
        n_fail++;
        $display("FAIL sat_ctrl cyc %0d: ctrl=%b expected %b", i, ctrl, e);
      end
      if (i == 10) begin
        n_chk++;
        if (load_stall_cnt !== 2'd3) begin
          n_fail++;
          $display("FAIL sat_lcnt: got %0d expected 3", load_stall_cnt);
        end
      end
      if (i == 11) begin
        n_chk++;
        if (fsm_state !== 1'b1 || flush_cnt !== 2'd1) begin
          n_fail++;
          $display("FAIL mid_flush: st=%b fcnt=%0d expected 1 and 1", fsm_state, flush_cnt);
        end
      end
    end
    n_chk++;
    if ({fsm_state, load_stall_cnt, flush_cnt, mem_timeout} !== '0) begin
      n_fail++;
      $display("FAIL reset_abort: st=%b lcnt=%0d fcnt=%0d to=%b expected all 0",
               fsm_state, load_stall_cnt, flush_cnt, mem_timeout);
    end
  endtask

  task automatic test_random();
    stim_t s;
    logic [5:0] e;
    for (int i = 0; i < 400; i++) begin
      s = mk(($urandom_range(0, 39) == 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
             1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0));
      drive(s);
      e = exp_q.pop_front();
      n_chk++;
      if (ctrl !== e) begin
        n_fail++;
        $display("FAIL random_ctrl cyc %0d: ctrl=%b expected %b", i, ctrl, e);
      end
      n_chk++;
      if ({fsm_state, load_stall_cnt, flush_cnt, mem_timeout} !== {m_flush, m_lcnt, m_fcnt, m_to}) begin
        n_fail++;
        $display("FAIL random_regs cyc %0d: st=%b lcnt=%0d fcnt=%0d to=%b expected %b %0d %0d %b",
                 i, fsm_state, load_stall_cnt, flush_cnt, mem_timeout, m_flush, m_lcnt, m_fcnt, m_to);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0_unused();
    test_branch();
    test_freeze();
    test_timeout();
    test_saturation_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
